// File: rtl/key_debounce_capture.sv
// Debounced pushbutton capture: 2-flop sync, per-key stability counter, press strobe, sticky press flags.
// Optional macro KEY_RELEASE_CAPTURE_EN adds sticky release flags (release_capture).
module key_debounce_capture #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_KEYS-1:0] edge_clear,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] edge_capture
`ifdef KEY_RELEASE_CAPTURE_EN
    ,
    output logic [NUM_KEYS-1:0] release_capture
`endif
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] level_c;
    logic [NUM_KEYS-1:0] differ_c;
    logic [NUM_KEYS-1:0] toggle_c;
    logic [NUM_KEYS-1:0] press_c;
    logic [CW-1:0]       cnt      [NUM_KEYS];
    logic [CW-1:0]       cnt_next [NUM_KEYS];

    // Per-key stability counter: restarts on equality, toggles the level at threshold
    always_comb begin
        level_c  = ~sync2;
        differ_c = level_c ^ key_level;
        toggle_c = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            cnt_next[i] = '0;
            if (differ_c[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    toggle_c[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
        press_c = toggle_c & ~key_level;
    end

    // Sticky flags also honour the registered pulse so a clear during the pulse cycle loses
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1        <= '1;
            sync2        <= '1;
            key_level    <= '0;
            press_pulse  <= '0;
            edge_capture <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1        <= key_n;
            sync2        <= sync1;
            key_level    <= key_level ^ toggle_c;
            press_pulse  <= press_c;
            edge_capture <= (edge_capture & ~edge_clear) | press_c | press_pulse;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

`ifdef KEY_RELEASE_CAPTURE_EN
    logic [NUM_KEYS-1:0] release_c;
    logic [NUM_KEYS-1:0] release_pulse;

    assign release_c = toggle_c & key_level;

    // Release flags mirror the press flags, sharing edge_clear
    always_ff @(posedge clk) begin
        if (reset) begin
            release_pulse   <= '0;
            release_capture <= '0;
        end else begin
            release_pulse   <= release_c;
            release_capture <= (release_capture & ~edge_clear) | release_c | release_pulse;
        end
    end
`endif

endmodule
